// File: rtl/wbu_txcompact.sv
// wbu_txcompact
//   Turns the deword stage's 7-bit newline/hexbit stream into printable ASCII
//   for the UART. Hexbits map onto the bus alphabet (0-9, A-Z, a-z, '@', '%').
//   Per-word newline markers are compacted: a newline goes out only at a word
//   boundary once the line holds at least MAX_LINE characters, or after the
//   stream has sat idle for IDLE_CYCLES with a partial line ended at a word
//   boundary.
//
// Ports
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   i_stb         upstream valid
//   i_nl_hexbits  bit 6 = newline marker, else bits 5:0 = hexbit value
//   o_busy        stall to upstream (o_stb && i_tx_busy)
//   o_stb         character valid to UART
//   o_char        ASCII character
//   i_tx_busy     UART stall
module wbu_txcompact #(
  parameter int MAX_LINE    = 72,
  parameter int IDLE_CYCLES = 1024,
  parameter int LGIDLE      = 11
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_stb,
  input  logic [6:0] i_nl_hexbits,
  output logic       o_busy,
  output logic       o_stb,
  output logic [7:0] o_char,
  input  logic       i_tx_busy
);

  // Line counter is wide enough to hold MAX_LINE plus the longest word, with
  // headroom; it saturates rather than wrapping.
  localparam int                LENW     = $clog2(MAX_LINE + 8);
  localparam logic [LENW-1:0]   LEN_SAT  = '1;
  localparam logic [LENW-1:0]   LEN_MAX  = LENW'(MAX_LINE);
  localparam logic [LGIDLE-1:0] IDLE_MAX = LGIDLE'(IDLE_CYCLES);

  logic [LENW-1:0]   r_len;
  logic              r_wend;
  logic [LGIDLE-1:0] r_idle;

  logic       acc;
  logic [5:0] hexbit;
  logic [7:0] mapped;

  assign o_busy = o_stb && i_tx_busy;
  assign acc    = i_stb && !o_busy;
  assign hexbit = i_nl_hexbits[5:0];

  // NOTE: every branch assigns 'mapped' after a default, so no latch is inferred.
  always_comb begin
    mapped = 8'h00;
    if (hexbit < 6'd10)
      mapped = 8'h30 + 8'(hexbit);
    else if (hexbit < 6'd36)
      mapped = 8'h37 + 8'(hexbit);
    else if (hexbit < 6'd62)
      mapped = 8'h3D + 8'(hexbit);
    else if (hexbit == 6'd62)
      mapped = 8'h40;
    else
      mapped = 8'h25;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stb  <= 1'b0;
      o_char <= 8'h00;
      r_len  <= '0;
      r_wend <= 1'b0;
      r_idle <= '0;
    end else if (acc) begin
      r_idle <= '0;
      if (!i_nl_hexbits[6]) begin
        o_stb  <= 1'b1;
        o_char <= mapped;
        r_len  <= (r_len == LEN_SAT) ? r_len : r_len + 1'b1;
        r_wend <= 1'b0;
      end else if (r_len == '0) begin
        // Marker on an empty line carries no information.
        o_stb <= 1'b0;
      end else if (r_len >= LEN_MAX) begin
        o_stb  <= 1'b1;
        o_char <= 8'h0A;
        r_len  <= '0;
        r_wend <= 1'b0;
      end else begin
        // Short line: remember the word boundary so an idle flush may end it.
        o_stb  <= 1'b0;
        r_wend <= 1'b1;
      end
    end else if (r_idle == IDLE_MAX && !i_stb && !o_stb) begin
      o_stb  <= 1'b1;
      o_char <= 8'h0A;
      r_len  <= '0;
      r_wend <= 1'b0;
      r_idle <= '0;
    end else begin
      if (!o_busy)
        o_stb <= 1'b0;
      if (r_wend && r_len != '0 && !i_stb && !o_stb && r_idle != IDLE_MAX)
        r_idle <= r_idle + 1'b1;
    end
  end

endmodule

// File: tb/tb_wbu_txcompact.sv
// Testbench for wbu_txcompact. Two instances share all inputs: dut_a uses the
// default MAX_LINE=72 / IDLE_CYCLES=1024, dut_b uses MAX_LINE=8 / IDLE_CYCLES=16
// for the line-breaking case. Each section starts from a fresh reset.
module tb_wbu_txcompact;

  logic       clk;
  logic       reset;
  logic       stb;
  logic [6:0] nl_hexbits;
  logic       tx_busy;

  logic       a_busy, a_stb;
  logic [7:0] a_char;
  logic       b_busy, b_stb;
  logic [7:0] b_char;

  int tests = 0;
  int fails = 0;

  wbu_txcompact dut_a (
    .i_clk(clk), .i_reset(reset), .i_stb(stb), .i_nl_hexbits(nl_hexbits),
    .o_busy(a_busy), .o_stb(a_stb), .o_char(a_char), .i_tx_busy(tx_busy)
  );

  wbu_txcompact #(.MAX_LINE(8), .IDLE_CYCLES(16), .LGIDLE(5)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_stb(stb), .i_nl_hexbits(nl_hexbits),
    .o_busy(b_busy), .o_stb(b_stb), .o_char(b_char), .i_tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] hexbits;
    logic [7:0] exp_char;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] v);
    stb        = 1'b1;
    nl_hexbits = v;
    step();
  endtask

  task automatic do_reset();
    stb     = 1'b0;
    tx_busy = 1'b0;
    reset   = 1'b1;
    step();
    step();
    reset   = 1'b0;
  endtask

  initial begin
    int n;
    int extra;

    stb        = 1'b0;
    nl_hexbits = 7'h00;
    tx_busy    = 1'b0;
    reset      = 1'b1;
    #1;

    vecs[0] = '{7'h00, 8'h30};
    vecs[1] = '{7'h0A, 8'h41};
    vecs[2] = '{7'h24, 8'h61};
    vecs[3] = '{7'h3E, 8'h40};
    vecs[4] = '{7'h3F, 8'h25};
    vecs[5] = '{7'h09, 8'h39};
    vecs[6] = '{7'h23, 8'h5A};
    vecs[7] = '{7'h3D, 8'h7A};

    // Reset state
    do_reset();
    check("reset_stb", 32'(a_stb), 32'd0);
    check("reset_char", 32'(a_char), 32'h00);
    check("reset_busy", 32'(a_busy), 32'd0);

    // Character map, one per cycle, one-cycle latency
    foreach (vecs[i]) begin
      send(vecs[i].hexbits);
      check($sformatf("map_stb[%0d]", i), 32'(a_stb), 32'd1);
      check($sformatf("map_char[%0d]", i), 32'(a_char), 32'(vecs[i].exp_char));
    end
    stb = 1'b0;
    step();
    check("map_drain_stb", 32'(a_stb), 32'd0);

    // Two markers on an empty line: no output, never busy
    do_reset();
    for (int k = 0; k < 2; k++) begin
      send(7'h40);
      check($sformatf("dbl_nl_stb[%0d]", k), 32'(a_stb), 32'd0);
      check($sformatf("dbl_nl_busy[%0d]", k), 32'(a_busy), 32'd0);
    end
    stb = 1'b0;

    // Line compaction on dut_b (MAX_LINE=8): newline after every 2nd 6-char word
    do_reset();
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 6; c++) send(7'(c + 1));
      send(7'h40);
      check($sformatf("line_nl_stb[w%0d]", w), 32'(b_stb), 32'(w % 2));
      if (w % 2 == 1)
        check($sformatf("line_nl_char[w%0d]", w), 32'(b_char), 32'h0A);
    end
    stb = 1'b0;
    step();

    // Idle flush on dut_a: 4 chars, marker, then one newline after 1024 idle cycles
    do_reset();
    for (int c = 0; c < 4; c++) send(7'(c + 10));
    send(7'h40);
    check("idle_marker_dropped", 32'(a_stb), 32'd0);
    stb = 1'b0;
    n = 0;
    while (!a_stb && n < 1100) begin
      step();
      n++;
    end
    check("idle_latency", 32'(n), 32'd1025);
    check("idle_nl_char", 32'(a_char), 32'h0A);
    extra = 0;
    for (int k = 0; k < 1100; k++) begin
      step();
      if (a_stb) extra++;
    end
    check("idle_single_nl", 32'(extra), 32'd0);

    // UART stall: 'Z' held, upstream held, then transfer and next accept
    do_reset();
    send(7'h23);
    check("stall_first", 32'(a_char), 32'h5A);
    tx_busy    = 1'b1;
    nl_hexbits = 7'h01;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("stall_char[%0d]", k), 32'(a_char), 32'h5A);
      check($sformatf("stall_stb[%0d]", k), 32'(a_stb), 32'd1);
      check($sformatf("stall_busy[%0d]", k), 32'(a_busy), 32'd1);
    end
    tx_busy = 1'b0;
    step();
    check("stall_release_char", 32'(a_char), 32'h31);
    check("stall_release_stb", 32'(a_stb), 32'd1);
    stb = 1'b0;
    step();

    // Reset mid-character with 20 chars on the line
    do_reset();
    for (int c = 0; c < 20; c++) send(7'(c));
    check("rst_mid_pre_stb", 32'(b_stb), 32'd1);
    stb   = 1'b0;
    reset = 1'b1;
    step();
    check("rst_mid_stb_a", 32'(a_stb), 32'd0);
    check("rst_mid_stb_b", 32'(b_stb), 32'd0);
    reset = 1'b0;
    send(7'h40);
    check("rst_mid_nl_a", 32'(a_stb), 32'd0);
    check("rst_mid_nl_b", 32'(b_stb), 32'd0);
    stb = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
